neuron_accum_ctrl: RTL and testbench
====================================

# neuron_accum_ctrl

Sequencer that time-multiplexes a single 18-bit signed adder to accumulate one neuron's weighted-input products plus bias into a saturated 18-bit pre-activation sum. Sits between the multiplier stage, which streams one 18-bit product per beat, and the activation stage, which consumes one sum per neuron. Both sides use a valid/ready handshake. It replaces a per-neuron adder tree with one adder plus a counter and FSM.

## Interface
Parameters:
- NUM_TERMS, 16: products accumulated per neuron; legal range 1..1024.
- CNT_W, $clog2(NUM_TERMS+1): term counter width; derived, not overridden.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle pulse; begins a neuron; honoured only in IDLE.
- bias  in  18  signed bias, sampled on the start cycle.
- in_valid  in  1  product beat valid.
- in_data  in  18  signed product (Q-format matches the multiplier output).
- in_ready  out  1  high only in ACCUM.
- out_valid  out  1  high only in DONE.
- out_data  out  18  signed saturated sum.
- out_ready  in  1  downstream accepts the sum.
- busy  out  1  high in ACCUM or DONE.
- sat_flag  out  1  sticky per neuron; 1 if any addition clamped.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1: acc <= bias, cnt <= 0, sat_flag <= 0, go to ACCUM.
  - start=0: hold state; acc and out_data keep their previous values.
- ACCUM:
  - Each beat with in_valid & in_ready: acc <= sat(acc + in_data), cnt <= cnt+1.
  - The beat that makes cnt == NUM_TERMS moves the FSM to DONE.
  - Cycles without a beat change nothing.
- DONE:
  - out_valid=1, out_data=acc.
  - out_ready=1: go to IDLE.
- Arithmetic:
  - Sum is computed at 19 bits, sign-extended.
  - sat(): sums > 131071 clamp to 131071 (0x1FFFF); sums < -131072 clamp to -131072 (0x20000); otherwise take the low 18 bits.
  - Any clamp sets sat_flag.
  - Saturation applies per addition, not only at the end.
- start outside IDLE is ignored, with no side effects and no queuing.
- in_data is ignored outside ACCUM; in_ready=0 there, so no beat can be accepted.
- Reset value of every output: in_ready=0, out_valid=0, out_data=0, busy=0, sat_flag=0. Internal state: FSM=IDLE, acc=0, cnt=0.
- rst asserted mid-operation, in any state, aborts the neuron. The partial sum is discarded and no out_valid is produced.

## Timing
- start at cycle t: in_ready=1 from t+1.
- Last beat accepted at cycle k: out_valid=1 at k+1. Pipeline latency is one cycle.
- in_ready depends on state only, with no combinational path from in_valid.
- out_valid and out_data depend on registers only.
- out_valid holds and out_data is stable until out_ready is sampled high. Back-pressure may last any number of cycles.
- Handshake at cycle d: IDLE at d+1; a start at d+1 is accepted.
- Minimum neuron period is NUM_TERMS+2 cycles: start, NUM_TERMS beats, DONE.
- NUM_TERMS=1: one beat takes ACCUM to DONE.
- Back-to-back beats are accepted every cycle with no bubbles.

## Structure
- Shared package nn_pkg:
  - DATA_W=18, SUM_W=19.
  - SAT_MAX=18'sh1FFFF, SAT_MIN=18'sh20000.
  - State enum type (IDLE, ACCUM, DONE).
- Sub-module sat_add18: combinational 18+18 → 19-bit signed add plus clamp. Outputs an 18-bit result and a clamp bit. One instance, shared across all beats.
- FSM, counter and accumulator register are in the top level.

## Test plan
- NUM_TERMS=4, bias=10, beats 1,2,3,4 back-to-back: out_valid 5 cycles after start; out_data=20, sat_flag=0.
- Positive clamp: bias=131000, beats 100,-50,0,0. Second addition uses the clamped value 131071: out_data=131021, sat_flag=1.
- Negative clamp: bias=-131072, beats -1,0,0,0: out_data=-131072, sat_flag=1.
- in_valid toggling 1,0,1,0… plus out_ready held 0 for 5 cycles in DONE:
  - Only valid beats are counted.
  - out_data is stable throughout.
  - IDLE the cycle after out_ready=1.
- start pulsed during ACCUM and DONE: ignored; acc and cnt unaffected; result correct.
- rst pulsed after the 2nd beat: outputs reset to 0 next cycle. A fresh start with bias=0 and beats 5,5,5,5 gives out_data=20.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath: data widths, saturation
// limits and the accumulation sequencer state type.
package nn_pkg;

  localparam int DATA_W = 18;
  localparam int SUM_W  = 19;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 18'sh1FFFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 18'sh20000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_add18.sv
// Combinational 18+18 signed add carried out at 19 bits, then clamped back
// into the 18-bit range. clamp_o reports that the result was pinned to a
// rail.
module sat_add18
  import nn_pkg::*;
(
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] sum_o,
  output logic                     clamp_o
);

  logic signed [SUM_W-1:0] wide_sum;

  // The two top bits of the 19-bit sum disagree exactly when the value
  // falls outside the 18-bit range. The top bit gives the overflow direction.
  always_comb begin
    wide_sum = {a_i[DATA_W-1], a_i} + {b_i[DATA_W-1], b_i};
    sum_o    = wide_sum[DATA_W-1:0];
    clamp_o  = 1'b0;
    if (wide_sum[SUM_W-1] != wide_sum[SUM_W-2]) begin
      clamp_o = 1'b1;
      sum_o   = wide_sum[SUM_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/neuron_accum_ctrl.sv
// Single-adder accumulation sequencer for one neuron.
// The accumulator is loaded with the bias, adds NUM_TERMS streamed products
// with per-addition saturation, and then offers the sum downstream.
module neuron_accum_ctrl
  import nn_pkg::*;
#(
  parameter int NUM_TERMS = 16,
  parameter int CNT_W     = $clog2(NUM_TERMS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     sat_flag
);

  // Counter value in the cycle that accepts the final product.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     sat_q, sat_d;

  logic                     beat;
  logic signed [DATA_W-1:0] add_sum;
  logic                     add_clamp;

  // This is the only adder. Every beat feeds it the running accumulator.
  sat_add18 u_add (
    .a_i    (acc_q),
    .b_i    (in_data),
    .sum_o  (add_sum),
    .clamp_o(add_clamp)
  );

  assign beat = in_valid && (state_q == ST_ACCUM);

  // Next-state logic for the FSM, term counter, accumulator and sticky clamp flag.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = bias;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          acc_d = add_sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (add_clamp) begin
            sat_d = 1'b1;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. A reset in any state discards the partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Outputs are driven only from registers. There is no path from in_valid to in_ready.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
  assign out_data  = acc_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_neuron_accum_ctrl.sv
// Bench for neuron_accum_ctrl with NUM_TERMS=4. It runs directed scenarios
// followed by randomized neurons. An integer-arithmetic model of the
// saturating accumulation supplies every expected value.
module tb_neuron_accum_ctrl;

  localparam int NT = 4;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [17:0] bias;
  logic               in_valid;
  logic signed [17:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic signed [17:0] out_data;
  logic               out_ready;
  logic               busy;
  logic               sat_flag;

  int n_checks;
  int n_fail;
  int cyc;
  int beats[NT];

  neuron_accum_ctrl #(.NUM_TERMS(NT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy),
    .sat_flag (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stop the run if it hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference model: clamp each partial sum to the 18-bit signed range.
  task automatic model(input int b, output int sum, output bit flag);
    sum  = b;
    flag = 1'b0;
    for (int i = 0; i < NT; i++) begin
      sum = sum + beats[i];
      if (sum > 131071) begin
        sum = 131071;
        flag = 1'b1;
      end else if (sum < -131072) begin
        sum = -131072;
        flag = 1'b1;
      end
    end
  endtask

  // Process one neuron. gap inserts idle cycles between beats, bp holds
  // back-pressure in DONE, and spam drives start while the FSM is busy.
  task automatic run_neuron(input int b, input bit gap, input int bp, input bit spam);
    int  exp_sum;
    bit  exp_flag;
    int  t0;
    int  idx;
    int  k;
    bit  v;
    model(b, exp_sum, exp_flag);
    check("idle_in_ready", {17'b0, in_ready}, 18'd0);
    t0 = cyc;
    start = 1'b1;
    bias  = 18'(b);
    step();
    start = 1'b0;
    bias  = 18'($urandom);
    check("accum_in_ready", {17'b0, in_ready}, 18'd1);
    check("accum_busy", {17'b0, busy}, 18'd1);
    check("accum_sat_clr", {17'b0, sat_flag}, 18'd0);
    idx = 0;
    k   = 0;
    while (idx < NT && k < 100) begin
      v = gap ? (k % 2 == 0) : 1'b1;
      in_valid = v;
      in_data  = v ? 18'(beats[idx]) : 18'($urandom);
      if (spam) begin
        start = 1'b1;
        bias  = 18'($urandom);
      end
      check("accum_no_valid", {17'b0, out_valid}, 18'd0);
      step();
      if (v) idx++;
      k++;
    end
    in_valid = 1'b0;
    in_data  = 18'($urandom);
    check("beats_done", 18'(idx), 18'(NT));
    if (!gap) check("latency", 18'(cyc - t0), 18'(NT + 1));
    check("done_valid", {17'b0, out_valid}, 18'd1);
    check("done_in_ready", {17'b0, in_ready}, 18'd0);
    check("sum", out_data, 18'(exp_sum));
    check("sat_flag", {17'b0, sat_flag}, {17'b0, exp_flag});
    for (int i = 0; i < bp; i++) begin
      out_ready = 1'b0;
      step();
      check("bp_valid", {17'b0, out_valid}, 18'd1);
      check("bp_stable", out_data, 18'(exp_sum));
    end
    start     = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_valid", {17'b0, out_valid}, 18'd0);
    check("idle_busy", {17'b0, busy}, 18'd0);
    check("idle_hold", out_data, 18'(exp_sum));
  endtask

  task automatic set_beats(input int a, input int b, input int c, input int d);
    beats[0] = a;
    beats[1] = b;
    beats[2] = c;
    beats[3] = d;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", {17'b0, in_ready}, 18'd0);
    check("rst_out_valid", {17'b0, out_valid}, 18'd0);
    check("rst_out_data", out_data, 18'd0);
    check("rst_busy", {17'b0, busy}, 18'd0);
    check("rst_sat", {17'b0, sat_flag}, 18'd0);
    rst = 1'b0;
    step();

    $display("[TB] basic back-to-back neuron");
    set_beats(1, 2, 3, 4);
    run_neuron(10, 1'b0, 0, 1'b0);

    $display("[TB] positive clamp");
    set_beats(100, -50, 0, 0);
    run_neuron(131000, 1'b0, 0, 1'b0);

    $display("[TB] negative clamp");
    set_beats(-1, 0, 0, 0);
    run_neuron(-131072, 1'b0, 0, 1'b0);

    $display("[TB] gapped beats with back-pressure");
    set_beats(7, -3, 1000, -20);
    run_neuron(-5, 1'b1, 5, 1'b0);

    $display("[TB] start pulsed while busy");
    set_beats(11, 22, 33, 44);
    run_neuron(1, 1'b0, 3, 1'b1);

    $display("[TB] reset mid-neuron");
    start = 1'b1;
    bias  = 18'sd999;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 18'sd100;
    step();
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check("abort_out_data", out_data, 18'd0);
    check("abort_busy", {17'b0, busy}, 18'd0);
    check("abort_in_ready", {17'b0, in_ready}, 18'd0);
    check("abort_out_valid", {17'b0, out_valid}, 18'd0);
    set_beats(5, 5, 5, 5);
    run_neuron(0, 1'b0, 0, 1'b0);

    $display("[TB] randomized neurons");
    for (int n = 0; n < 24; n++) begin
      int b;
      int range;
      range = (n % 3 == 0) ? 131072 : 40000;
      for (int i = 0; i < NT; i++) begin
        beats[i] = int'($urandom_range(0, 2 * range - 1)) - range;
      end
      b = int'($urandom_range(0, 262143)) - 131072;
      run_neuron(b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
